pcpi_fpu_seq: RTL and testbench

- PCPI-side sequencer for the single-precision FP engine attached to the picorv32 co-processor port.
- Decodes OP-FP instructions (fadd.s, fsub.s, fmul.s) and latches rs1/rs2. It then issues one start pulse to a multi-cycle FP engine and waits for its done.
- Returns the result through pcpi_wr/pcpi_rd/pcpi_ready and accumulates IEEE exception flags.
- Guards against a hung engine (watchdog) and against core-side abandonment (pcpi_valid drop).

---
 rtl/pcpi_fpu_pkg.sv | 30 +++
 rtl/pcpi_fpu_decode.sv | 27 ++
 rtl/pcpi_fpu_seq.sv | 129 ++++++++++++
 tb/tb_pcpi_fpu_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_fpu_pkg.sv
// Shared encodings for the PCPI single-precision FP sequencer:
// FSM states, engine op codes, OP-FP decode fields and flag bit positions.
package pcpi_fpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    localparam logic [6:0] OPCODE_OPFP = 7'b1010011;
    localparam logic [6:0] FUNCT7_FADD = 7'b0000000;
    localparam logic [6:0] FUNCT7_FSUB = 7'b0000100;
    localparam logic [6:0] FUNCT7_FMUL = 7'b0001000;

    // fflags bit positions, RISC-V order NV,DZ,OF,UF,NX
    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/pcpi_fpu_decode.sv
// OP-FP instruction decoder: recognises fadd.s/fsub.s/fmul.s and maps them
// to an engine op code. The rounding mode and register fields are ignored.
module pcpi_fpu_decode
    import pcpi_fpu_pkg::*;
(
    input  logic [31:0] insn,
    output logic        match,
    output logic [1:0]  op
);

    logic unused_fields;
    assign unused_fields = ^insn[24:7];

    always_comb begin
        match = 1'b0;
        op    = OP_ADD;
        if (insn[6:0] == OPCODE_OPFP) begin
            case (insn[31:25])
                FUNCT7_FADD: begin match = 1'b1; op = OP_ADD; end
                FUNCT7_FSUB: begin match = 1'b1; op = OP_SUB; end
                FUNCT7_FMUL: begin match = 1'b1; op = OP_MUL; end
                default:     begin match = 1'b0; op = OP_ADD; end
            endcase
        end
    end

endmodule

// File: rtl/pcpi_fpu_seq.sv
// PCPI-side sequencer for a multi-cycle single-precision FP engine: accepts
// OP-FP instructions, drives the engine, returns results and sticky flags.
module pcpi_fpu_seq
    import pcpi_fpu_pkg::*;
#(
    parameter int unsigned  ENG_TIMEOUT    = 64,
    parameter logic [31:0]  TIMEOUT_RESULT = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        eng_start,
    output logic [1:0]  eng_op,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    output logic        eng_abort,
    input  logic        eng_done,
    input  logic [31:0] eng_result,
    input  logic [4:0]  eng_flags,
    output logic [4:0]  fflags,
    input  logic        fflags_clr
);

    localparam logic [9:0] WDOG_LAST = 10'(ENG_TIMEOUT - 1);
    localparam logic [4:0] NV_ONLY   = 5'(1) << FLAG_NV;

    state_t      state;
    logic [9:0]  wdog;
    logic [31:0] result;
    logic [4:0]  res_flags;
    logic        guard;
    logic        abandon_abort;
    logic        match;
    logic [1:0]  dec_op;
    logic        wd_expire;
    logic        wd_abort;

    pcpi_fpu_decode u_decode (
        .insn  (pcpi_insn),
        .match (match),
        .op    (dec_op)
    );

    assign wd_expire = (wdog == WDOG_LAST);
    // The watchdog only aborts when the core is still waiting and the engine
    // has not answered in the same cycle; abandonment uses the registered pulse.
    assign wd_abort  = (state == WAIT) && pcpi_valid && !eng_done && wd_expire;

    assign eng_start  = (state == ISSUE);
    assign eng_abort  = abandon_abort | wd_abort;
    assign pcpi_wait  = (state != IDLE);
    assign pcpi_ready = (state == RESP);
    assign pcpi_wr    = (state == RESP);
    assign pcpi_rd    = (state == RESP) ? result : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            wdog          <= '0;
            result        <= '0;
            res_flags     <= '0;
            guard         <= 1'b0;
            abandon_abort <= 1'b0;
            eng_op        <= '0;
            eng_a         <= '0;
            eng_b         <= '0;
            fflags        <= '0;
        end else begin
            abandon_abort <= 1'b0;
            guard         <= (state == RESP);

            case (state)
                IDLE: begin
                    if (pcpi_valid && match && !guard) begin
                        eng_op <= dec_op;
                        eng_a  <= pcpi_rs1;
                        eng_b  <= pcpi_rs2;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog <= '0;
                    if (!pcpi_valid) begin
                        abandon_abort <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!pcpi_valid) begin
                        abandon_abort <= 1'b1;
                        state         <= IDLE;
                    end else if (eng_done) begin
                        result    <= eng_result;
                        res_flags <= eng_flags;
                        state     <= RESP;
                    end else if (wd_expire) begin
                        result    <= TIMEOUT_RESULT;
                        res_flags <= NV_ONLY;
                        state     <= RESP;
                    end else begin
                        wdog <= wdog + 10'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (state == RESP) begin
                fflags <= fflags_clr ? res_flags : (fflags | res_flags);
            end else if (fflags_clr) begin
                fflags <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pcpi_fpu_seq.sv
// Scoreboard bench for pcpi_fpu_seq: directed instructions with a scripted
// engine; expected responses are queued and checked when pcpi_ready fires.
module tb_pcpi_fpu_seq;
    import pcpi_fpu_pkg::*;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        eng_start;
    logic [1:0]  eng_op;
    logic [31:0] eng_a;
    logic [31:0] eng_b;
    logic        eng_abort;
    logic        eng_done;
    logic [31:0] eng_result;
    logic [4:0]  eng_flags;
    logic [4:0]  fflags;
    logic        fflags_clr;

    pcpi_fpu_seq #(
        .ENG_TIMEOUT    (TO),
        .TIMEOUT_RESULT (32'h7FC0_0000)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready),
        .eng_start  (eng_start),
        .eng_op     (eng_op),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_abort  (eng_abort),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .eng_flags  (eng_flags),
        .fflags     (fflags),
        .fflags_clr (fflags_clr)
    );

    typedef struct {
        logic [31:0] rd;
        logic [4:0]  ff;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [4:0]  exp_fflags = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every pcpi_ready must match the oldest queued expectation;
    // the sticky flags are checked one cycle later, after their update edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && pcpi_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 32'(pcpi_rd), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rd", pcpi_rd, e.rd);
                    chk("resp_wr", 32'(pcpi_wr), 32'd1);
                    @(negedge clk);
                    chk("resp_fflags", 32'(fflags), 32'(e.ff));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    // n == 0 means the engine never answers and the watchdog must fire.
    task automatic run_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] exp_op, input int unsigned n,
                          input logic [31:0] res, input logic [4:0] flg,
                          input bit clr_resp, input bit hold);
        exp_t        e;
        logic [4:0]  newf;
        int unsigned last;
        newf       = (n == 0) ? 5'b10000 : flg;
        exp_fflags = clr_resp ? newf : (exp_fflags | newf);
        e.rd       = (n == 0) ? 32'h7FC0_0000 : res;
        e.ff       = exp_fflags;
        sb.push_back(e);
        last = (n == 0) ? TO : n;

        tick();
        pcpi_valid = 1'b1;
        pcpi_insn  = insn;
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        tick();
        chk("issue_start", 32'(eng_start), 32'd1);
        chk("issue_wait", 32'(pcpi_wait), 32'd1);
        chk("issue_op", 32'(eng_op), 32'(exp_op));
        chk("issue_a", eng_a, a);
        chk("issue_b", eng_b, b);
        for (int unsigned i = 1; i <= last; i++) begin
            tick();
            if (i == n) begin
                eng_done   = 1'b1;
                eng_result = res;
                eng_flags  = flg;
            end
            #1;
            chk("wait_abort", 32'(eng_abort), 32'((n == 0) && (i == TO)));
            chk("wait_start", 32'(eng_start), 32'd0);
        end
        tick();
        eng_done   = 1'b0;
        eng_result = '0;
        eng_flags  = '0;
        fflags_clr = clr_resp;
        chk("resp_latency", 32'(pcpi_ready), 32'd1);
        chk("resp_no_abort", 32'(eng_abort), 32'd0);
        tick();
        fflags_clr = 1'b0;
        if (!hold) pcpi_valid = 1'b0;
        chk("ready_one_cycle", 32'(pcpi_ready), 32'd0);
        chk("idle_rd_zero", pcpi_rd, 32'd0);
        if (hold) begin
            tick();
            pcpi_valid = 1'b0;
            chk("stale_no_start", 32'(eng_start), 32'd0);
            chk("stale_no_wait", 32'(pcpi_wait), 32'd0);
        end
    endtask

    initial begin
        int unsigned bad;
        resetn     = 1'b0;
        pcpi_valid = 1'b0;
        pcpi_insn  = '0;
        pcpi_rs1   = '0;
        pcpi_rs2   = '0;
        eng_done   = 1'b0;
        eng_result = '0;
        eng_flags  = '0;
        fflags_clr = 1'b0;
        repeat (3) tick();
        chk("rst_wr", 32'(pcpi_wr), 32'd0);
        chk("rst_rd", pcpi_rd, 32'd0);
        chk("rst_wait", 32'(pcpi_wait), 32'd0);
        chk("rst_ready", 32'(pcpi_ready), 32'd0);
        chk("rst_start", 32'(eng_start), 32'd0);
        chk("rst_op", 32'(eng_op), 32'd0);
        chk("rst_a", eng_a, 32'd0);
        chk("rst_b", eng_b, 32'd0);
        chk("rst_abort", 32'(eng_abort), 32'd0);
        chk("rst_fflags", 32'(fflags), 32'd0);
        resetn = 1'b1;
        tick();

        // fmul.s 3.0 * 2.0 = 6.0, engine takes 5 cycles
        run_op(32'h1020_8053, 32'h4040_0000, 32'h4000_0000, OP_MUL, 5,
               32'h40C0_0000, 5'b00000, 1'b0, 1'b0);
        // fadd.s 1.0 + 2.0 with NX, then clear the sticky flags in IDLE
        run_op(32'h0031_0253, 32'h3F80_0000, 32'h4000_0000, OP_ADD, 2,
               32'h4040_0000, 5'b00001, 1'b0, 1'b0);
        tick();
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        exp_fflags = '0;
        chk("clr_idle", 32'(fflags), 32'd0);

        // fsub.s at minimum latency (engine answers in the first WAIT cycle)
        run_op(32'h0820_8053, 32'h4040_0000, 32'h3F80_0000, OP_SUB, 1,
               32'h4000_0000, 5'b00101, 1'b0, 1'b0);

        // non-OP-FP integer add must be ignored
        tick();
        pcpi_valid = 1'b1;
        pcpi_insn  = 32'h0020_8033;
        bad = 0;
        repeat (20) begin
            tick();
            if (pcpi_wait || pcpi_ready || eng_start) bad++;
        end
        pcpi_valid = 1'b0;
        chk("nonfp_silent", 32'(bad), 32'd0);

        // hung engine: watchdog abort, qNaN result, NV raised
        run_op(32'h1020_8053, 32'h4040_0000, 32'h4000_0000, OP_MUL, 0,
               32'h0, 5'b00000, 1'b0, 1'b0);

        // core abandons 2 cycles into WAIT, late done is ignored
        tick();
        pcpi_valid = 1'b1;
        pcpi_insn  = 32'h1020_8053;
        pcpi_rs1   = 32'h4040_0000;
        pcpi_rs2   = 32'h4040_0000;
        tick();
        chk("abn_start", 32'(eng_start), 32'd1);
        tick();
        tick();
        pcpi_valid = 1'b0;
        #1;
        chk("abn_no_early_abort", 32'(eng_abort), 32'd0);
        tick();
        chk("abn_abort", 32'(eng_abort), 32'd1);
        chk("abn_idle", 32'(pcpi_wait), 32'd0);
        eng_done   = 1'b1;
        eng_result = 32'h1234_5678;
        eng_flags  = 5'b11111;
        tick();
        eng_done   = 1'b0;
        eng_result = '0;
        eng_flags  = '0;
        chk("abn_abort_once", 32'(eng_abort), 32'd0);
        chk("abn_no_ready", 32'(pcpi_ready), 32'd0);
        chk("abn_no_wait", 32'(pcpi_wait), 32'd0);
        chk("abn_fflags", 32'(fflags), 32'(exp_fflags));

        // new fmul accepted normally; valid held one cycle past ready
        run_op(32'h1020_8053, 32'h4040_0000, 32'h4040_0000, OP_MUL, 3,
               32'h4110_0000, 5'b00000, 1'b0, 1'b1);

        // done coincident with watchdog expiry: engine result wins
        run_op(32'h0020_8053, 32'h4000_0000, 32'h4040_0000, OP_ADD, TO,
               32'h40A0_0000, 5'b00000, 1'b0, 1'b0);

        // fflags_clr during RESP: only the new flags remain
        run_op(32'h1020_8053, 32'h0080_0000, 32'h0080_0000, OP_MUL, 2,
               32'h0000_0000, 5'b00010, 1'b1, 1'b0);

        repeat (4) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
